// File: rtl/instr_fetch_unit_pkg.sv
// Shared widths and FSM encoding for the instruction fetch slice.
package instr_fetch_unit_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 32;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with occupancy count; used for both the fetch tag queue
// and the decoded-side instruction buffer.
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             wdata_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  always_comb begin
    pop_ok   = pop_i && (count_q != '0);
    push_ok  = push_i && ((count_q != CW'(DEPTH)) || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
      else if (!push_ok && pop_ok) count_d = count_q - CW'(1);
    end
  end

  // Storage is cleared on reset so the head reads as zero until first push.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_ok && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: issues word-aligned requests, pairs in-order responses
// with their PCs and buffers them for decode; redirects flush and drain.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned           FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  if_valid,
  input  logic                  if_ready,
  output logic [DATA_WIDTH-1:0] if_instr,
  output logic [ADDR_WIDTH-1:0] if_pc
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BW = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] RESET_PC_W = {RESET_PC[ADDR_WIDTH-1:2], 2'b00};
  localparam logic [CW:0] DEPTH_C = FIFO_DEPTH[CW:0];

  fetch_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0]         discard_q, discard_d;
  logic [CW-1:0]         tag_count, buf_count;
  logic [ADDR_WIDTH-1:0] tag_pc;
  logic [BW-1:0]         buf_head;
  logic [CW:0]           occupancy;
  logic                  req_fire, buf_push, buf_pop;
  logic                  unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // A pop committed this cycle frees an entry before any new response can
  // land, so it is credited here to sustain one fetch per cycle.
  always_comb begin
    if_valid      = !rst && (buf_count != '0) && !redirect_valid;
    buf_pop       = if_valid && if_ready;
    occupancy     = {1'b0, tag_count} + {1'b0, buf_count} - {{CW{1'b0}}, buf_pop};
    mem_req_valid = !rst && (state_q == RUN) && !redirect_valid && (occupancy < DEPTH_C);
    req_fire      = mem_req_valid && mem_req_ready;
    buf_push      = mem_rsp_valid && (state_q == RUN) && !redirect_valid;
    mem_req_addr  = pc_q;
    if_instr      = buf_head[DATA_WIDTH-1:0];
    if_pc         = buf_head[BW-1:DATA_WIDTH];
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    discard_d = discard_q;
    if (redirect_valid) begin
      pc_d      = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      discard_d = tag_count - CW'(mem_rsp_valid);
      state_d   = (discard_d != '0) ? DRAIN : RUN;
    end else begin
      if (req_fire) pc_d = pc_q + ADDR_WIDTH'(4);
      if ((state_q == DRAIN) && mem_rsp_valid) begin
        discard_d = discard_q - CW'(1);
        if (discard_q == CW'(1)) state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      pc_q      <= RESET_PC_W;
      discard_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      discard_q <= discard_d;
    end
  end

  // Every response retires one tag, including those dropped while draining.
  fetch_fifo #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_tag_q (
    .clk     (clk),
    .rst     (rst),
    .flush_i (1'b0),
    .push_i  (req_fire),
    .wdata_i (pc_q),
    .pop_i   (mem_rsp_valid),
    .rdata_o (tag_pc),
    .count_o (tag_count)
  );

  fetch_fifo #(
    .WIDTH (BW),
    .DEPTH (FIFO_DEPTH)
  ) u_instr_buf (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_valid),
    .push_i  (buf_push),
    .wdata_i ({tag_pc, mem_rsp_data}),
    .pop_i   (buf_pop),
    .rdata_o (buf_head),
    .count_o (buf_count)
  );

endmodule
